// File: rtl/row_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among the cores of a mesh row.
// Read data returns tagged to the issuing core through a READ_LATENCY-deep tag pipeline.
module row_dmem_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_en,
    input  logic [NUM_REQ-1:0]            req_wr_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_en,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr_r;
    logic [PW-1:0]      winner_s;
    logic               found_s;
    logic [PW-1:0]      next_ptr_s;
    logic [NUM_REQ-1:0] push_tag_s;
    logic [NUM_REQ-1:0] tag_r [READ_LATENCY];

    // Scan requesters starting at the round-robin pointer; the first active one wins.
    always_comb begin
        int sum_v;
        sum_v    = 0;
        winner_s = rr_ptr_r;
        found_s  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v = int'(rr_ptr_r) + k;
            if (sum_v >= NUM_REQ) begin
                sum_v = sum_v - NUM_REQ;
            end else begin
                sum_v = sum_v;
            end
            if (!found_s && req_en[PW'(sum_v)]) begin
                found_s  = 1'b1;
                winner_s = PW'(sum_v);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // One-hot grant and winner mux onto the shared memory port; grant is held off during reset.
    always_comb begin
        grant     = '0;
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (found_s && !reset) begin
            grant[winner_s] = 1'b1;
            mem_en          = 1'b1;
            mem_wr_en       = req_wr_en[winner_s];
            mem_addr        = req_addr[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata       = req_wdata[winner_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            grant = '0;
        end
    end

    // Pointer successor and the tag pushed for this cycle (writes push an empty tag).
    always_comb begin
        if (winner_s == PW'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_s + 1'b1;
        end
        if (mem_en && !mem_wr_en) begin
            push_tag_s = grant;
        end else begin
            push_tag_s = '0;
        end
    end

    // Round-robin pointer advances past each granted core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (mem_en) begin
            rr_ptr_r <= next_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Read-tag shift register; reset drops any reads still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            tag_r[0] <= push_tag_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    assign rvalid = tag_r[READ_LATENCY-1];

    // Shared read-data bus is quiet unless some core owns it this cycle.
    always_comb begin
        if (|rvalid) begin
            rdata = mem_rdata;
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: tb/tb_row_dmem_arbiter.sv
// Self-checking bench: three arbiters (READ_LATENCY 1, 2, 3) share stimulus, each with its own memory model.
module tb_row_dmem_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_en;
    logic [3:0]   req_wr_en;
    logic [127:0] req_addr;
    logic [255:0] req_wdata;

    logic [3:0]  grant_a     [3];
    logic [3:0]  rvalid_a    [3];
    logic [63:0] rdata_a     [3];
    logic        mem_en_a    [3];
    logic        mem_wr_a    [3];
    logic [31:0] mem_addr_a  [3];
    logic [63:0] mem_wdata_a [3];
    logic [63:0] mem_rdata_a [3];

    logic [63:0] mem  [3][32];
    logic [63:0] pipe [3][4];

    int n_chk;
    int n_bad;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        row_dmem_arbiter #(
            .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .READ_LATENCY(g + 1)
        ) dut (
            .clk(clk), .reset(reset),
            .req_en(req_en), .req_wr_en(req_wr_en),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .grant(grant_a[g]), .rvalid(rvalid_a[g]), .rdata(rdata_a[g]),
            .mem_en(mem_en_a[g]), .mem_wr_en(mem_wr_a[g]),
            .mem_addr(mem_addr_a[g]), .mem_wdata(mem_wdata_a[g]),
            .mem_rdata(mem_rdata_a[g])
        );
        assign mem_rdata_a[g] = pipe[g][g];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] fdat(input logic [31:0] addr);
        return 64'hC0DE_0000_0000_0000 | {32'h0, addr};
    endfunction

    // Preload: every word holds its own address tagged with C0DE.
    initial begin
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 32; k++) begin
                mem[g][k] <= fdat(32'(k * 8));
            end
        end
    end

    // Synchronous memory models: write on the edge, read data delayed by each instance's latency.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mem_en_a[g] && mem_wr_a[g]) begin
                mem[g][mem_addr_a[g][7:3]] <= mem_wdata_a[g];
            end
            pipe[g][0] <= (mem_en_a[g] && !mem_wr_a[g]) ? mem[g][mem_addr_a[g][7:3]] : 64'h0;
            for (int k = 1; k < 4; k++) begin
                pipe[g][k] <= pipe[g][k-1];
            end
        end
    end

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic [3:0] wr;
        logic [3:0] gnt;
        logic [3:0] rv;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int core_of(input logic [3:0] oh);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) c = i;
        end
        return c;
    endfunction

    task automatic set_core(input int i, input logic [31:0] addr, input logic [63:0] data);
        req_addr[i*32 +: 32]  = addr;
        req_wdata[i*64 +: 64] = data;
    endtask

    task automatic drive(input logic [3:0] en, input logic [3:0] wr);
        @(negedge clk);
        req_en    = en;
        req_wr_en = wr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_en    = 4'b0000;
        req_wr_en = 4'b0000;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ea;
        logic [63:0] ed;
        n_chk     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        req_en    = 4'b1111;
        req_wr_en = 4'b0000;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 4; i++) set_core(i, 32'h40 + 32'(i * 8), 64'hA000 + 64'(i));
        #1;
        reset = 1'b1;

        //            rst   en       wr       gnt      rv
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0001};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0010};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0100};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b1000};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0001};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0010};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0100};
        vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        vecs[10] = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 4'b0000};
        vecs[11] = '{1'b0, 4'b1010, 4'b0000, 4'b1000, 4'b0010};
        vecs[12] = '{1'b0, 4'b0110, 4'b0110, 4'b0010, 4'b1000};
        vecs[13] = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 4'b0000};
        vecs[14] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0100};
        vecs[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

        // Reset behaviour, round-robin rotation and mixed patterns on the latency-1 instance.
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            reset     = vecs[v].rst;
            req_en    = vecs[v].en;
            req_wr_en = vecs[v].wr;
            #1;
            ea = (vecs[v].gnt == 4'b0000) ? 32'h0 : 32'h40 + 32'(core_of(vecs[v].gnt) * 8);
            ed = (vecs[v].gnt == 4'b0000) ? 64'h0 : 64'hA000 + 64'(core_of(vecs[v].gnt));
            chk($sformatf("v%0d grant", v), 64'(grant_a[0]), 64'(vecs[v].gnt));
            chk($sformatf("v%0d mem_en", v), 64'(mem_en_a[0]), 64'(|vecs[v].gnt));
            chk($sformatf("v%0d mem_wr_en", v), 64'(mem_wr_a[0]), 64'(|(vecs[v].gnt & vecs[v].wr)));
            chk($sformatf("v%0d mem_addr", v), 64'(mem_addr_a[0]), 64'(ea));
            chk($sformatf("v%0d mem_wdata", v), mem_wdata_a[0], ed);
            chk($sformatf("v%0d rvalid", v), 64'(rvalid_a[0]), 64'(vecs[v].rv));
            chk($sformatf("v%0d rdata", v), rdata_a[0],
                (vecs[v].rv == 4'b0000) ? 64'h0 : fdat(32'h40 + 32'(core_of(vecs[v].rv) * 8)));
        end

        // Single core read at latency 1, preceded by a write of the value it returns.
        do_reset();
        set_core(2, 32'h10, 64'hDEAD);
        drive(4'b0100, 4'b0100);
        chk("t3 write grant", 64'(grant_a[0]), 64'h4);
        chk("t3 write mem_wr_en", 64'(mem_wr_a[0]), 64'h1);
        drive(4'b0100, 4'b0000);
        chk("t3 read grant", 64'(grant_a[0]), 64'h4);
        chk("t3 read mem_addr", 64'(mem_addr_a[0]), 64'h10);
        chk("t3 write no rvalid", 64'(rvalid_a[0]), 64'h0);
        drive(4'b0000, 4'b0000);
        chk("t3 rvalid", 64'(rvalid_a[0]), 64'h4);
        chk("t3 rdata", rdata_a[0], 64'hDEAD);

        // Write by core 1 and read by core 3 to the same address in the same cycle.
        do_reset();
        set_core(1, 32'h20, 64'hBEEF);
        set_core(3, 32'h20, 64'h0);
        drive(4'b1010, 4'b0010);
        chk("t4 write first", 64'(grant_a[0]), 64'h2);
        chk("t4 write wdata", mem_wdata_a[0], 64'hBEEF);
        drive(4'b1000, 4'b0000);
        chk("t4 read grant", 64'(grant_a[0]), 64'h8);
        chk("t4 read mem_wr_en", 64'(mem_wr_a[0]), 64'h0);
        chk("t4 write no rvalid", 64'(rvalid_a[0]), 64'h0);
        drive(4'b0000, 4'b0000);
        chk("t4 rvalid", 64'(rvalid_a[0]), 64'h8);
        chk("t4 rdata", rdata_a[0], 64'hBEEF);

        // Back-to-back reads from all cores on the latency-3 instance.
        do_reset();
        for (int i = 0; i < 4; i++) set_core(i, 32'h80 + 32'(i * 8), 64'h0);
        drive(4'b1111, 4'b0000);
        chk("t5 grant c0", 64'(grant_a[2]), 64'h1);
        drive(4'b1110, 4'b0000);
        chk("t5 grant c1", 64'(grant_a[2]), 64'h2);
        drive(4'b1100, 4'b0000);
        chk("t5 grant c2", 64'(grant_a[2]), 64'h4);
        chk("t5 no early rvalid", 64'(rvalid_a[2]), 64'h0);
        drive(4'b1000, 4'b0000);
        chk("t5 grant c3", 64'(grant_a[2]), 64'h8);
        chk("t5 rvalid c0", 64'(rvalid_a[2]), 64'h1);
        chk("t5 rdata c0", rdata_a[2], fdat(32'h80));
        for (int k = 1; k < 4; k++) begin
            drive(4'b0000, 4'b0000);
            chk($sformatf("t5 rvalid c%0d", k), 64'(rvalid_a[2]), 64'(4'b0001 << k));
            chk($sformatf("t5 rdata c%0d", k), rdata_a[2], fdat(32'h80 + 32'(k * 8)));
        end
        drive(4'b0000, 4'b0000);
        chk("t5 rvalid idle", 64'(rvalid_a[2]), 64'h0);

        // Reset one cycle after a read grant on the latency-2 instance.
        do_reset();
        drive(4'b0010, 4'b0000);
        drive(4'b0001, 4'b0000);
        chk("t6 read grant", 64'(grant_a[1]), 64'h1);
        @(negedge clk);
        reset  = 1'b1;
        req_en = 4'b1111;
        #1;
        chk("t6 grant in reset", 64'(grant_a[1]), 64'h0);
        chk("t6 rvalid in reset", 64'(rvalid_a[1]), 64'h0);
        @(negedge clk);
        reset  = 1'b0;
        req_en = 4'b0000;
        #1;
        chk("t6 rvalid after release", 64'(rvalid_a[1]), 64'h0);
        chk("t6 rdata after release", rdata_a[1], 64'h0);
        drive(4'b0000, 4'b0000);
        chk("t6 rvalid later", 64'(rvalid_a[1]), 64'h0);
        drive(4'b0011, 4'b0000);
        chk("t6 pointer reset", 64'(grant_a[1]), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
